// File: rtl/punc_ctrl_hs_if.sv
// Controller <-> datapath/memory bundle for punc_ctrl_hs; master = controller, slave = datapath side.
// The retired counter port exists only when PUNC_CTRL_PERF_EN is defined.
interface punc_ctrl_hs_if
`ifdef PUNC_CTRL_PERF_EN
   #(parameter int CNT_W = 32)
`endif
   ;
   logic [15:0] ir;
   logic        nzp_match;
   logic        mem_ack;
   logic        resume;
   logic        ir_ld, ir_clr;
   logic        pc_ld, pc_clr, pc_inc;
   logic [1:0]  pc_sel;
   logic        mem_req, mem_we;
   logic [1:0]  mem_addr_sel;
   logic        rf_wr, rf_w_addr_sel;
   logic [1:0]  rf_w_data_sel;
   logic        rf_rp_sel;
   logic [1:0]  alu_sel;
   logic        alu_a_sel;
   logic        temp_ld;
   logic        nzp_ld, nzp_clr;
   logic        halted, mem_err;
   logic [2:0]  state_o;
`ifdef PUNC_CTRL_PERF_EN
   logic [CNT_W-1:0] retired;
`endif

   modport master (
      input  ir, nzp_match, mem_ack, resume,
      output ir_ld, ir_clr, pc_ld, pc_clr, pc_inc, pc_sel,
             mem_req, mem_we, mem_addr_sel,
             rf_wr, rf_w_addr_sel, rf_w_data_sel, rf_rp_sel,
             alu_sel, alu_a_sel, temp_ld, nzp_ld, nzp_clr,
             halted, mem_err, state_o
`ifdef PUNC_CTRL_PERF_EN
      , output retired
`endif
   );

   modport slave (
      output ir, nzp_match, mem_ack, resume,
      input  ir_ld, ir_clr, pc_ld, pc_clr, pc_inc, pc_sel,
             mem_req, mem_we, mem_addr_sel,
             rf_wr, rf_w_addr_sel, rf_w_data_sel, rf_rp_sel,
             alu_sel, alu_a_sel, temp_ld, nzp_ld, nzp_clr,
             halted, mem_err, state_o
`ifdef PUNC_CTRL_PERF_EN
      , input retired
`endif
   );
endinterface

// File: rtl/punc_ctrl_hs.sv
// PUnC LC3 multi-cycle controller: req/ack memory handshake with timeout, resumable HALT, one-cycle JSR/JSRR.
// Outputs are combinational from state/ir/nzp_match/mem_ack; PUNC_CTRL_PERF_EN adds the retired counter.
module punc_ctrl_hs #(
   parameter int MEM_TIMEOUT = 16
`ifdef PUNC_CTRL_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic           clk,
   input  logic           rst,
   punc_ctrl_hs_if.master bus
);
   typedef enum logic [2:0] {
      S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
      S_EXEC2 = 3'd4, S_HALT = 3'd5, S_ERR = 3'd6
   } state_t;

   localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
   localparam logic [3:0] OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100;
   localparam logic [3:0] OP_HLT = 4'b1101, OP_LEA = 4'b1110;

   localparam int            WW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] W_LIM = (MEM_TIMEOUT > 0) ? WW'(MEM_TIMEOUT - 1) : '0;

   state_t          r_state;
   state_t          w_next;
   logic [WW-1:0]   r_wait;
   logic [3:0]      w_op;
   logic            w_wait;
   logic            w_timeout;
   logic            w_unused;

   assign w_op      = bus.ir[15:12];
   assign w_unused  = ^{bus.ir[10:6], bus.ir[4:0]};
   assign w_wait    = bus.mem_req && !bus.mem_ack;
   // The timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT; an ack that cycle wins.
   assign w_timeout = (MEM_TIMEOUT != 0) && w_wait && (r_wait == W_LIM);
   assign bus.state_o = r_state;

   always_comb begin
      bus.ir_ld = 1'b0;  bus.ir_clr = 1'b0;
      bus.pc_ld = 1'b0;  bus.pc_clr = 1'b0;  bus.pc_inc = 1'b0;  bus.pc_sel = 2'd0;
      bus.mem_req = 1'b0;  bus.mem_we = 1'b0;  bus.mem_addr_sel = 2'd0;
      bus.rf_wr = 1'b0;  bus.rf_w_addr_sel = 1'b0;  bus.rf_w_data_sel = 2'd0;  bus.rf_rp_sel = 1'b0;
      bus.alu_sel = 2'd0;  bus.alu_a_sel = 1'b0;  bus.temp_ld = 1'b0;
      bus.nzp_ld = 1'b0;  bus.nzp_clr = 1'b0;  bus.halted = 1'b0;  bus.mem_err = 1'b0;
      case (r_state)
         S_INIT: begin
            bus.pc_clr = 1'b1;  bus.ir_clr = 1'b1;  bus.nzp_clr = 1'b1;
         end
         S_FETCH: begin
            bus.mem_req = 1'b1;
            bus.ir_ld   = bus.mem_ack;
            bus.pc_inc  = bus.mem_ack;
         end
         S_EXEC: begin
            case (w_op)
               OP_ADD, OP_AND: begin
                  bus.rf_wr = 1'b1;  bus.nzp_ld = 1'b1;
                  bus.alu_sel   = (w_op == OP_AND) ? 2'd1 : 2'd0;
                  bus.alu_a_sel = bus.ir[5];
               end
               OP_NOT: begin
                  bus.alu_sel = 2'd2;  bus.rf_wr = 1'b1;  bus.nzp_ld = 1'b1;
               end
               OP_LEA: begin
                  bus.rf_w_data_sel = 2'd2;  bus.rf_wr = 1'b1;  bus.nzp_ld = 1'b1;
               end
               OP_BR:  bus.pc_ld = bus.nzp_match;
               OP_JMP: begin
                  bus.pc_ld = 1'b1;  bus.pc_sel = 2'd2;
               end
               OP_JSR: begin
                  // Link write and jump share one edge, so JSRR R7 targets the old R7.
                  bus.rf_wr = 1'b1;  bus.rf_w_addr_sel = 1'b1;  bus.rf_w_data_sel = 2'd3;
                  bus.pc_ld = 1'b1;  bus.pc_sel = bus.ir[11] ? 2'd1 : 2'd2;
               end
               OP_LD, OP_LDR: begin
                  bus.mem_req      = 1'b1;
                  bus.mem_addr_sel = (w_op == OP_LD) ? 2'd1 : 2'd2;
                  bus.rf_wr  = bus.mem_ack;
                  bus.nzp_ld = bus.mem_ack;
                  bus.rf_w_data_sel = bus.mem_ack ? 2'd1 : 2'd0;
               end
               OP_ST, OP_STR: begin
                  bus.mem_req      = 1'b1;  bus.mem_we = 1'b1;  bus.rf_rp_sel = 1'b1;
                  bus.mem_addr_sel = (w_op == OP_ST) ? 2'd1 : 2'd2;
               end
               OP_LDI, OP_STI: begin
                  bus.mem_req = 1'b1;  bus.mem_addr_sel = 2'd1;  bus.temp_ld = bus.mem_ack;
               end
               default: ;
            endcase
         end
         S_EXEC2: begin
            bus.mem_req = 1'b1;  bus.mem_addr_sel = 2'd3;
            if (w_op == OP_STI) begin
               bus.mem_we = 1'b1;  bus.rf_rp_sel = 1'b1;
            end else begin
               bus.rf_wr  = bus.mem_ack;
               bus.nzp_ld = bus.mem_ack;
               bus.rf_w_data_sel = bus.mem_ack ? 2'd1 : 2'd0;
            end
         end
         S_HALT:  bus.halted  = 1'b1;
         S_ERR:   bus.mem_err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:   w_next = S_FETCH;
         S_FETCH:  if (bus.mem_ack) w_next = S_DECODE; else if (w_timeout) w_next = S_ERR;
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            if (w_op == OP_HLT)
               w_next = S_HALT;
            else if (!bus.mem_req)
               w_next = S_FETCH;
            else if (bus.mem_ack)
               w_next = (w_op == OP_LDI || w_op == OP_STI) ? S_EXEC2 : S_FETCH;
            else if (w_timeout)
               w_next = S_ERR;
         end
         S_EXEC2:  if (bus.mem_ack) w_next = S_FETCH; else if (w_timeout) w_next = S_ERR;
         S_HALT:   if (bus.resume) w_next = S_FETCH;
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INIT;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wait <= '0;
         else if (w_wait && MEM_TIMEOUT != 0)
            r_wait <= r_wait + WW'(1);
      end
   end

`ifdef PUNC_CTRL_PERF_EN
   logic [CNT_W-1:0] r_retired;

   always_ff @(posedge clk) begin
      if (rst || r_state == S_INIT)
         r_retired <= '0;
      else if (w_next == S_FETCH && (r_state == S_EXEC || r_state == S_EXEC2))
         r_retired <= r_retired + CNT_W'(1);
   end

   assign bus.retired = r_retired;
`endif
endmodule

// File: tb/tb_punc_ctrl_hs.sv
// Bench for punc_ctrl_hs: per-instruction step lists (accesses + side effects) checked every cycle against random ack delays.
module tb_punc_ctrl_hs;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   punc_ctrl_hs_if bus();
   punc_ctrl_hs #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic       ir_ld, ir_clr, pc_ld, pc_clr, pc_inc;
      logic [1:0] pc_sel;
      logic       mem_req, mem_we;
      logic [1:0] mem_addr_sel;
      logic       rf_wr, rf_w_addr_sel;
      logic [1:0] rf_w_data_sel;
      logic       rf_rp_sel;
      logic [1:0] alu_sel;
      logic       alu_a_sel, temp_ld, nzp_ld, nzp_clr, halted, mem_err;
      logic [2:0] st;
   } ov_t;

   typedef struct {
      bit  acc;
      ov_t wv;
      ov_t dv;
   } step_t;

   step_t steps[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    exp_ret = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic ov_t obs();
      ov_t o;
      o.ir_ld = bus.ir_ld;  o.ir_clr = bus.ir_clr;  o.pc_ld = bus.pc_ld;
      o.pc_clr = bus.pc_clr;  o.pc_inc = bus.pc_inc;  o.pc_sel = bus.pc_sel;
      o.mem_req = bus.mem_req;  o.mem_we = bus.mem_we;  o.mem_addr_sel = bus.mem_addr_sel;
      o.rf_wr = bus.rf_wr;  o.rf_w_addr_sel = bus.rf_w_addr_sel;  o.rf_w_data_sel = bus.rf_w_data_sel;
      o.rf_rp_sel = bus.rf_rp_sel;  o.alu_sel = bus.alu_sel;  o.alu_a_sel = bus.alu_a_sel;
      o.temp_ld = bus.temp_ld;  o.nzp_ld = bus.nzp_ld;  o.nzp_clr = bus.nzp_clr;
      o.halted = bus.halted;  o.mem_err = bus.mem_err;  o.st = bus.state_o;
      return o;
   endfunction

   function automatic ov_t mk(input int st);
      ov_t o = '0;
      o.st = 3'(st);
      return o;
   endfunction

   task automatic push(input bit acc, input ov_t wv, input ov_t dv);
      step_t s;
      s.acc = acc;  s.wv = wv;  s.dv = dv;
      steps.push_back(s);
   endtask

   // Instruction-level expectations: one entry per access (wait view + completion view) or plain cycle.
   task automatic build(input logic [15:0] ir, input logic nzp);
      ov_t w, d;
      steps.delete();
      w = mk(1);  w.mem_req = 1'b1;
      d = w;  d.ir_ld = 1'b1;  d.pc_inc = 1'b1;
      push(1, w, d);
      push(0, '0, mk(2));
      w = mk(3);  w.mem_req = 1'b1;
      d = mk(3);
      case (ir[15:12])
         4'b0001, 4'b0101: begin
            d.rf_wr = 1'b1;  d.nzp_ld = 1'b1;  d.alu_a_sel = ir[5];
            d.alu_sel = (ir[15:12] == 4'b0101) ? 2'd1 : 2'd0;
            push(0, '0, d);
         end
         4'b1001: begin d.alu_sel = 2'd2;  d.rf_wr = 1'b1;  d.nzp_ld = 1'b1;  push(0, '0, d); end
         4'b1110: begin d.rf_w_data_sel = 2'd2;  d.rf_wr = 1'b1;  d.nzp_ld = 1'b1;  push(0, '0, d); end
         4'b0000: begin d.pc_ld = nzp;  push(0, '0, d); end
         4'b1100: begin d.pc_ld = 1'b1;  d.pc_sel = 2'd2;  push(0, '0, d); end
         4'b0100: begin
            d.rf_wr = 1'b1;  d.rf_w_addr_sel = 1'b1;  d.rf_w_data_sel = 2'd3;
            d.pc_ld = 1'b1;  d.pc_sel = ir[11] ? 2'd1 : 2'd2;
            push(0, '0, d);
         end
         4'b0010, 4'b0110: begin
            w.mem_addr_sel = (ir[15:12] == 4'b0010) ? 2'd1 : 2'd2;
            d = w;  d.rf_wr = 1'b1;  d.rf_w_data_sel = 2'd1;  d.nzp_ld = 1'b1;
            push(1, w, d);
         end
         4'b0011, 4'b0111: begin
            w.mem_we = 1'b1;  w.rf_rp_sel = 1'b1;
            w.mem_addr_sel = (ir[15:12] == 4'b0011) ? 2'd1 : 2'd2;
            push(1, w, w);
         end
         4'b1010, 4'b1011: begin
            w.mem_addr_sel = 2'd1;
            d = w;  d.temp_ld = 1'b1;
            push(1, w, d);
            w = mk(4);  w.mem_req = 1'b1;  w.mem_addr_sel = 2'd3;
            if (ir[12]) begin
               w.mem_we = 1'b1;  w.rf_rp_sel = 1'b1;  d = w;
            end else begin
               d = w;  d.rf_wr = 1'b1;  d.rf_w_data_sel = 2'd1;  d.nzp_ld = 1'b1;
            end
            push(1, w, d);
         end
         default: push(0, '0, d);
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit with_resume);
      ov_t iv = mk(0);
      iv.pc_clr = 1'b1;  iv.ir_clr = 1'b1;  iv.nzp_clr = 1'b1;
      rst = 1'b1;
      bus.resume = with_resume;
      bus.mem_ack = 1'($urandom_range(0, 1));
      tick();
      bus.mem_ack = 1'($urandom_range(0, 1));
      #1 chk("reset_init", 32'(obs()), 32'(iv));
      exp_ret = 0;
`ifdef PUNC_CTRL_PERF_EN
      chk("retired_clr", 32'(bus.retired), 32'(exp_ret));
`endif
      rst = 1'b0;
      bus.resume = 1'b0;
      tick();
   endtask

   function automatic int pick(input int fd);
      if (fd >= 0) return fd;
      if ($urandom_range(0, 11) == 0) return $urandom_range(TO, TO + 2);
      return $urandom_range(0, TO - 1);
   endfunction

   // Entered one step after a rising edge with the DUT in FETCH; leaves it the same way.
   task automatic run_instr(input logic [15:0] ir, input logic nzp, input int fd,
                            input bit rst_in_halt, input int nh);
      bit err = 0;
      int d;
      ov_t hv = mk(5);
      ov_t ev = mk(6);
      hv.halted = 1'b1;
      ev.mem_err = 1'b1;
      bus.ir = ir;
      bus.nzp_match = nzp;
      build(ir, nzp);
      for (int i = 0; i < steps.size() && !err; i++) begin
         if (!steps[i].acc) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.resume  = 1'($urandom_range(0, 1));
            #1 chk("step", 32'(obs()), 32'(steps[i].dv));
            tick();
         end else begin
            d = pick(fd);
            for (int k = 0; k <= TO; k++) begin
               if (k == TO) begin
                  err = 1;
                  break;
               end
               bus.resume = 1'($urandom_range(0, 1));
               if (k == d) begin
                  bus.mem_ack = 1'b1;
                  #1 chk("ack", 32'(obs()), 32'(steps[i].dv));
                  tick();
                  break;
               end
               bus.mem_ack = 1'b0;
               #1 chk("wait", 32'(obs()), 32'(steps[i].wv));
               tick();
            end
         end
      end
      if (err) begin
         for (int k = 0; k < 3; k++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.resume  = 1'($urandom_range(0, 1));
            #1 chk("err", 32'(obs()), 32'(ev));
            tick();
         end
         do_reset(0);
      end else if (ir[15:12] == 4'b1101) begin
         for (int k = 0; k < nh; k++) begin
            bus.resume = 1'b0;
            bus.mem_ack = 1'($urandom_range(0, 1));
            #1 chk("halt", 32'(obs()), 32'(hv));
            tick();
         end
         if (rst_in_halt) begin
            do_reset(1);
         end else begin
            bus.resume = 1'b1;
            #1 chk("halt_resume", 32'(obs()), 32'(hv));
            tick();
            bus.resume = 1'b0;
         end
      end else begin
         exp_ret++;
      end
`ifdef PUNC_CTRL_PERF_EN
      chk("retired", 32'(bus.retired), 32'(exp_ret));
`endif
   endtask

   initial begin
      ov_t fw;
      logic [15:0] rir;
      bus.ir = '0;  bus.nzp_match = 1'b0;  bus.mem_ack = 1'b0;  bus.resume = 1'b0;
      fw = mk(1);  fw.mem_req = 1'b1;
      do_reset(0);
      run_instr(16'h5A7F, 1'b1, 0, 0, 0);   // AND, zero wait
      run_instr(16'h12A3, 1'b0, 3, 0, 0);   // ADD R1,R2,#3 with 3 wait cycles per access
      run_instr(16'hA5FF, 1'b0, 0, 0, 0);   // LDI
      run_instr(16'hB3FF, 1'b0, 2, 0, 0);   // STI
      run_instr(16'h41C0, 1'b0, 0, 0, 0);   // JSRR R7
      run_instr(16'h4C05, 1'b0, 1, 0, 0);   // JSR
      run_instr(16'h0E05, 1'b0, 0, 0, 0);   // BR not taken
      run_instr(16'h0E05, 1'b1, 0, 0, 0);   // BR taken
      run_instr(16'h6283, 1'b0, TO - 1, 0, 0);  // LDR, ack on the last legal cycle
      run_instr(16'h7283, 1'b0, TO - 1, 0, 0);  // STR
      run_instr(16'h1234, 1'b0, TO + 1, 0, 0);  // fetch timeout -> ERR -> reset
      run_instr(16'h2001, 1'b0, TO, 0, 0);      // ack one cycle too late -> ERR
      run_instr(16'hD000, 1'b0, 0, 0, 10);      // HLT then resume
      run_instr(16'hD000, 1'b0, 0, 1, 3);       // HLT, rst and resume together
      for (int k = 0; k < 2; k++) begin          // reset during a stalled fetch
         bus.mem_ack = 1'b0;
         #1 chk("fetch_wait_pre_rst", 32'(obs()), 32'(fw));
         tick();
      end
      do_reset(0);
      for (int n = 0; n < 250; n++) begin
         rir = 16'($urandom);
         run_instr(rir, 1'($urandom_range(0, 1)), -1, ($urandom_range(0, 7) == 0),
                   $urandom_range(1, 6));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
